// File: rtl/ddcpu_pkg.sv
// ddcpu_pkg
//  Shared definitions for the dataflow CPU interconnect and its buffers.
//  TOKEN_WIDTH        : width of a token on the merged interconnect output
//  FIFO_DEFAULT_DEPTH : default number of entries in a token buffer
//  token_t            : one token as carried on the interconnect
package ddcpu_pkg;

  localparam int TOKEN_WIDTH        = 32;
  localparam int FIFO_DEFAULT_DEPTH = 8;

  typedef logic [TOKEN_WIDTH-1:0] token_t;

endpackage

// File: rtl/token_fifo_mem.sv
// token_fifo_mem
//  DEPTH x DATA_WIDTH register array backing the token FIFO. One synchronous
//  write port, one asynchronous (combinational) read port, no reset: contents
//  are only meaningful where the FIFO pointers say a token lives.
//  Ports:
//   clk   in  1           rising-edge clock
//   we    in  1           write enable
//   waddr in  ADDR_WIDTH  write address
//   wdata in  DATA_WIDTH  write data
//   raddr in  ADDR_WIDTH  read address
//   rdata out DATA_WIDTH  contents at raddr, combinational
module token_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/token_fifo.sv
// token_fifo
//  Elastic token buffer on the merged output of the N:1 interconnect. Absorbs
//  bursts so the interconnect does not stall on a slow consumer. receive_ready
//  comes only from registered pointer state, so there is no combinational path
//  from send_ready back to the upstream side.
//  Optional feature macro: TOKEN_FIFO_BYPASS_EN -- when the buffer is empty a
//  token offered with send_ready high passes straight through in the same cycle
//  without being stored. Default build (macro undefined): no bypass, minimum
//  latency of one cycle, no combinational path receive_* -> send_*.
//  Ports:
//   clk           in  1            rising-edge clock
//   rst_n         in  1            async active-low reset
//   receive_valid in  1            upstream token valid
//   receive_data  in  DATA_WIDTH   upstream token
//   receive_ready out 1            buffer not full
//   send_valid    out 1            token available downstream
//   send_data     out DATA_WIDTH   head token
//   send_ready    in  1            downstream accepts
//   count         out ADDR_WIDTH+1 entries held, 0..DEPTH
module token_fifo
  import ddcpu_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH,
  parameter int DEPTH      = FIFO_DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  receive_valid,
  input  logic [DATA_WIDTH-1:0] receive_data,
  output logic                  receive_ready,
  output logic                  send_valid,
  output logic [DATA_WIDTH-1:0] send_data,
  input  logic                  send_ready,
  output logic [ADDR_WIDTH:0]   count
);

  // Refuse to build with a depth that the pointer width cannot describe.
  generate
    if ((DEPTH < 2) || (DEPTH != (1 << ADDR_WIDTH))) begin : g_bad_cfg
      $error("token_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_WIDTH");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit above the address so that full and
  // empty can be told apart when the addresses coincide.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_addr == rd_addr) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // Pointer difference modulo 2*DEPTH is exactly the occupancy.
  assign count         = wr_ptr - rd_ptr;
  assign receive_ready = !full;

`ifdef TOKEN_FIFO_BYPASS_EN
  // While empty, an offered token is presented at once; if the consumer takes
  // it in this cycle it never touches storage, otherwise it is written and
  // stays at the head next cycle.
  assign bypass     = empty && receive_valid && send_ready;
  assign send_valid = !empty || receive_valid;
  assign send_data  = empty ? receive_data : mem_rdata;
`else
  assign bypass     = 1'b0;
  assign send_valid = !empty;
  assign send_data  = mem_rdata;
`endif

  // A bypassed token is consumed directly, so it is neither written nor
  // popped from storage.
  assign push = receive_valid && receive_ready && !bypass;
  assign pop  = !empty && send_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  token_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_addr),
    .wdata(receive_data),
    .raddr(rd_addr),
    .rdata(mem_rdata)
  );

endmodule
